// File: rtl/mips_tb_pkg.sv
// Shared types and helpers for the MIPS run monitor: run state encoding,
// well-known addresses and the saturating counter step.
package mips_tb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } run_state_t;

    localparam logic [31:0] RESET_VECTOR      = 32'hBFC0_0000;
    localparam logic [31:0] DEFAULT_HALT_ADDR = 32'h0000_0000;

    // Increment value, holding at the all-ones pattern of a width-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
        logic [63:0] limit;
        logic [63:0] result;
        limit = (width >= 32'd64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        if (value >= limit) begin
            result = value;
        end else begin
            result = value + 64'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mips_run_trace_buf.sv
// Circular buffer of the most recent fetch addresses; sel=0 reads the newest
// entry. Used by mips_run_monitor only when RUN_MONITOR_TRACE_EN is defined.
module mips_run_trace_buf #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [31:0]              wr_addr,
    input  logic [$clog2(DEPTH)-1:0] sel,
    output logic [31:0]              rd_addr,
    output logic                     rd_valid
);

    localparam int SEL_W = $clog2(DEPTH);

    logic [31:0]      mem_r [DEPTH];
    logic [SEL_W-1:0] wptr_r;
    logic [SEL_W:0]   fill_r;
    logic [SEL_W-1:0] rd_idx_s;

    // Write side: pointer wraps naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_r <= '0;
            fill_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (clear) begin
            wptr_r <= '0;
            fill_r <= '0;
        end else if (wr_en) begin
            mem_r[wptr_r] <= wr_addr;
            wptr_r        <= wptr_r + SEL_W'(1);
            if (fill_r != (SEL_W+1)'(DEPTH)) begin
                fill_r <= fill_r + (SEL_W+1)'(1);
            end
        end
    end

    // Read side: index back from the newest entry.
    always_comb begin
        rd_idx_s = wptr_r - SEL_W'(1) - sel;
        rd_addr  = mem_r[rd_idx_s];
        rd_valid = ({1'b0, sel} < fill_r);
    end

endmodule

// File: rtl/mips_run_monitor.sv
// Run monitor for the Harvard MIPS test environment: halt detection, masked
// v0 check, cycle timeout and access statistics. Optional fetch trace via RUN_MONITOR_TRACE_EN.
module mips_run_monitor
    import mips_tb_pkg::*;
#(
    parameter int          CNT_W       = 16,
    parameter int          MAX_CYCLES  = 200,
    parameter logic [31:0] HALT_ADDR   = DEFAULT_HALT_ADDR,
    parameter int          TRACE_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [31:0]                    exp_v0,
    input  logic [31:0]                    exp_mask,
    input  logic                           active,
    input  logic [31:0]                    instr_address,
    input  logic [31:0]                    register_v0,
    input  logic                           data_read,
    input  logic                           data_write,
`ifdef RUN_MONITOR_TRACE_EN
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_sel,
    output logic [31:0]                    trace_addr,
    output logic                           trace_valid,
`endif
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic                           timeout,
    output logic [31:0]                    result_v0,
    output logic [CNT_W-1:0]               cycle_count,
    output logic [CNT_W-1:0]               fetch_count,
    output logic [CNT_W-1:0]               dread_count,
    output logic [CNT_W-1:0]               dwrite_count
);

    run_state_t       state_r;
    logic [31:0]      exp_r;
    logic [31:0]      mask_r;
    logic [31:0]      prev_addr_r;
    logic [31:0]      result_r;
    logic [CNT_W-1:0] cycle_r;
    logic [CNT_W-1:0] fetch_r;
    logic [CNT_W-1:0] dread_r;
    logic [CNT_W-1:0] dwrite_r;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;
    logic             timeout_r;

    logic launch_s;
    logic halt_s;
    logic fetch_hit_s;
    logic expire_s;
    logic match_s;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] value);
        return CNT_W'(sat_inc(64'(value), CNT_W));
    endfunction

    // Per-cycle event decode; halt takes priority over expiry.
    always_comb begin
        launch_s    = start && (state_r != ST_RUN);
        halt_s      = (state_r == ST_RUN) && !active && (instr_address == HALT_ADDR);
        fetch_hit_s = (state_r == ST_RUN) && active && (instr_address != prev_addr_r);
        expire_s    = (state_r == ST_RUN) && (cycle_r == CNT_W'(MAX_CYCLES - 1)) && !halt_s;
        match_s     = (((register_v0 ^ exp_r) & mask_r) == 32'h0000_0000);
    end

    // Run state machine with registered status and statistics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            exp_r       <= 32'h0000_0000;
            mask_r      <= 32'h0000_0000;
            prev_addr_r <= 32'h0000_0000;
            result_r    <= 32'h0000_0000;
            cycle_r     <= '0;
            fetch_r     <= '0;
            dread_r     <= '0;
            dwrite_r    <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    cycle_r     <= bump(cycle_r);
                    prev_addr_r <= instr_address;
                    if (data_read) begin
                        dread_r <= bump(dread_r);
                    end
                    if (data_write) begin
                        dwrite_r <= bump(dwrite_r);
                    end
                    if (fetch_hit_s) begin
                        fetch_r <= bump(fetch_r);
                    end
                    if (halt_s) begin
                        result_r <= register_v0;
                        state_r  <= match_s ? ST_PASS : ST_FAIL;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        pass_r   <= match_s;
                    end else if (expire_s) begin
                        result_r  <= register_v0;
                        state_r   <= ST_TIMEOUT;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        timeout_r <= 1'b1;
                    end
                end
                default: begin
                    if (launch_s) begin
                        exp_r       <= exp_v0;
                        mask_r      <= exp_mask;
                        prev_addr_r <= instr_address;
                        result_r    <= 32'h0000_0000;
                        cycle_r     <= '0;
                        fetch_r     <= '0;
                        dread_r     <= '0;
                        dwrite_r    <= '0;
                        state_r     <= ST_RUN;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                        pass_r      <= 1'b0;
                        timeout_r   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign pass         = pass_r;
    assign timeout      = timeout_r;
    assign result_v0    = result_r;
    assign cycle_count  = cycle_r;
    assign fetch_count  = fetch_r;
    assign dread_count  = dread_r;
    assign dwrite_count = dwrite_r;

`ifdef RUN_MONITOR_TRACE_EN
    mips_run_trace_buf #(
        .DEPTH(TRACE_DEPTH)
    ) u_trace (
        .clk      (clk),
        .reset    (reset),
        .clear    (launch_s),
        .wr_en    (fetch_hit_s),
        .wr_addr  (instr_address),
        .sel      (trace_sel),
        .rd_addr  (trace_addr),
        .rd_valid (trace_valid)
    );
`endif

endmodule
